// File: rtl/ipml_wr_pack_v1_0_pkg.sv
// rtl/ipml_wr_pack_v1_0_pkg.sv - shared constants and lane mapping for the write-side packer
// Contents:
//   RATIO_MIN / RATIO_MAX : legal range of beats per FIFO word
//   lane_idx()            : maps beat index k to its lane in the wide word
package ipml_wr_pack_v1_0_pkg;

    localparam int RATIO_MIN = 1;
    localparam int RATIO_MAX = 8;

    // Beat k lands in lane k when LSB_FIRST, otherwise the lane order is mirrored.
    function automatic int lane_idx(input int k, input int ratio, input bit lsb_first);
        return lsb_first ? k : (ratio - 1 - k);
    endfunction

endpackage

// File: rtl/ipml_reg_fifo_v1_0.sv
// rtl/ipml_reg_fifo_v1_0.sv - two-entry register FIFO used as the packer output stage
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   data_in/_valid/_ready         : push side, push when valid & ready
//   data_out/_valid/_ready        : pop side, head entry, pop when valid & ready
// data_in_ready depends only on the registered count. data_out is all zeros when empty.
module ipml_reg_fifo_v1_0
    import ipml_wr_pack_v1_0_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    output logic [W-1:0] data_out,
    output logic         data_out_valid,
    input  logic         data_out_ready
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    assign data_in_ready  = (cnt != 2'd2);
    assign data_out_valid = (cnt != 2'd0);
    assign data_out       = slot0;
    assign push           = data_in_valid & data_in_ready;
    assign pop            = data_out_valid & data_out_ready;

    // slot0 is always the head. Unoccupied slots are kept at zero so the head
    // reads as zero when the FIFO is empty without an extra output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else if (push && pop) begin
            // Only reachable with cnt == 1: the new word replaces the popped head.
            slot0 <= data_in;
        end else if (push) begin
            if (cnt == 2'd0) begin
                slot0 <= data_in;
            end else begin
                slot1 <= data_in;
            end
            cnt <= cnt + 2'd1;
        end else if (pop) begin
            slot0 <= slot1;
            slot1 <= '0;
            cnt   <= cnt - 2'd1;
        end
    end

endmodule

// File: rtl/ipml_wr_pack_v1_0.sv
// rtl/ipml_wr_pack_v1_0.sv - packs RATIO narrow beats into one wide FIFO write word
// Ports:
//   clk, rst_n                            : clock, asynchronous active-low reset
//   data_in/_valid/_last/_ready           : narrow beat stream, last closes the current word
//   wr_data, wr_keep, wr_en               : FIFO write port with per-lane keep mask
//   wr_vld                                : FIFO not-full, gates wr_en combinationally
//   pending                               : accumulator holds a partial word
module ipml_wr_pack_v1_0
    import ipml_wr_pack_v1_0_pkg::*;
#(
    parameter int W_IN      = 32,
    parameter int RATIO     = 2,
    parameter bit LSB_FIRST = 1'b1,
    localparam int W_OUT    = W_IN * RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_IN-1:0]  data_in,
    input  logic             data_in_valid,
    input  logic             data_in_last,
    output logic             data_in_ready,
    output logic [W_OUT-1:0] wr_data,
    output logic [RATIO-1:0] wr_keep,
    output logic             wr_en,
    input  logic             wr_vld,
    output logic             pending
);

    localparam int               IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [W_OUT-1:0]       acc_data;
    logic [RATIO-1:0]       acc_keep;
    logic [IDX_W-1:0]       idx;
    logic                   acc;
    logic                   word_done;
    int                     cur_lane;
    logic [W_OUT-1:0]       next_data;
    logic [RATIO-1:0]       next_keep;
    logic                   fifo_in_ready;
    logic                   fifo_out_valid;
    logic [W_OUT+RATIO-1:0] fifo_out;

    assign acc       = data_in_valid & data_in_ready;
    assign word_done = acc & ((idx == LAST_IDX) | data_in_last);

    // Accumulator contents with the incoming beat merged in. This is what gets
    // pushed on a completing beat, so the final beat never waits a cycle.
    always_comb begin
        cur_lane  = lane_idx(int'(idx), RATIO, LSB_FIRST);
        next_data = acc_data;
        next_keep = acc_keep;
        for (int l = 0; l < RATIO; l++) begin
            if (cur_lane == l) begin
                next_data[l*W_IN +: W_IN] = data_in;
                next_keep[l]              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (acc) begin
            if (word_done) begin
                acc_data <= '0;
                acc_keep <= '0;
                idx      <= '0;
            end else begin
                acc_data <= next_data;
                acc_keep <= next_keep;
                idx      <= idx + IDX_ONE;
            end
        end
    end

    ipml_reg_fifo_v1_0 #(
        .W (W_OUT + RATIO)
    ) u_out_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        ({next_keep, next_data}),
        .data_in_valid  (word_done),
        .data_in_ready  (fifo_in_ready),
        .data_out       (fifo_out),
        .data_out_valid (fifo_out_valid),
        .data_out_ready (wr_en)
    );

    // Ready comes from the output stage count alone, so a full stage stalls
    // partial-word beats too; wr_vld only reaches wr_en through a single AND.
    assign data_in_ready      = fifo_in_ready;
    assign wr_en              = fifo_out_valid & wr_vld;
    assign {wr_keep, wr_data} = fifo_out;
    assign pending            = (idx != '0);

endmodule
